// File: rtl/ysyx_23060278_idu.sv
// NPC instruction-decode stage: one registered beat of decoded RV32I/RV64I fields.
// Define YSYX_23060278_IDU_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module ysyx_23060278_idu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [5:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int PW = 2 * XLEN + 39;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  logic [5:0]             fmt_p0;
  logic                   illegal_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic signed [11:0]     imm_i;
  logic signed [11:0]     imm_s;
  logic signed [12:0]     imm_b;
  logic signed [31:0]     imm_u;
  logic signed [20:0]     imm_j;
  logic [PW-1:0]          dec_p0;
  logic [PW-1:0]          out_p1;
  logic                   vld_p1;

  assign imm_i = $signed(in_inst[31:20]);
  assign imm_s = $signed({in_inst[31:25], in_inst[11:7]});
  assign imm_b = $signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
  assign imm_u = $signed({in_inst[31:12], 12'b0});
  assign imm_j = $signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});

  // Stage p0: combinational decode of the presented instruction
  always_comb begin
    fmt_p0     = '0;
    illegal_p0 = 1'b0;
    imm_p0     = '0;
    case (in_inst[6:0])
      7'b0110011: fmt_p0 = FMT_R;
      7'b0111011: if (XLEN == 32) illegal_p0 = 1'b1; else fmt_p0 = FMT_R;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011: fmt_p0 = FMT_I;
      7'b0011011: if (XLEN == 32) illegal_p0 = 1'b1; else fmt_p0 = FMT_I;
      7'b0100011: fmt_p0 = FMT_S;
      7'b1100011: fmt_p0 = FMT_B;
      7'b0110111, 7'b0010111: fmt_p0 = FMT_U;
      7'b1101111: fmt_p0 = FMT_J;
      default:    illegal_p0 = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) illegal_p0 = 1'b1;
    if (illegal_p0) fmt_p0 = '0;
    case (fmt_p0)
      FMT_I:   imm_p0 = XLEN'(imm_i);
      FMT_S:   imm_p0 = XLEN'(imm_s);
      FMT_B:   imm_p0 = XLEN'(imm_b);
      FMT_U:   imm_p0 = XLEN'(imm_u);
      FMT_J:   imm_p0 = XLEN'(imm_j);
      default: imm_p0 = '0;
    endcase
  end

  assign dec_p0 = {in_pc, in_inst[6:0], in_inst[19:15], in_inst[24:20], in_inst[11:7],
                   in_inst[14:12], in_inst[31:25], fmt_p0, imm_p0, illegal_p0};

  // Stage p1: output register (plus optional skid entry)
`ifdef YSYX_23060278_IDU_SKID_EN
  logic [PW-1:0] skid_p1;
  logic          skid_vld_p1;

  assign in_ready = rst_n & ~skid_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      // Output slot frees up: the skid is older than any new beat, so it goes first
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end else if (in_valid) begin
        out_p1 <= dec_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (in_valid && in_ready) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end
`else
  assign in_ready = rst_n & (~vld_p1 | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      out_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_p1 <= dec_p0;
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  assign out_valid = vld_p1;
  assign {out_pc, out_opcode, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
          out_fmt, out_imm, out_illegal} = out_p1;

endmodule

// File: doc/ysyx_23060278_idu.md
# ysyx_23060278_idu

Registered, parametrised instruction-decode stage for the NPC core, between IFU and EXU. Accepts one 32-bit RISC-V instruction plus its PC per valid/ready beat. Emits the decoded fields, a one-hot format, an XLEN-wide sign-extended immediate and an illegal flag, one cycle later. Supports RV32I/RV64I base opcodes, backpressure and a pipeline flush.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64. Sets the immediate and PC widths.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous kill of every buffered beat.
- `in_valid` input 1: IFU beat valid.
- `in_ready` output 1: IDU can accept.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction PC.
- `out_valid` output 1: decoded beat valid.
- `out_ready` input 1: EXU accepts.
- `out_pc` output XLEN: PC carried through unchanged.
- `out_opcode`, `out_rs1`, `out_rs2`, `out_rd`, `out_funct3`, `out_funct7` outputs 7/5/5/5/3/7: raw fields from inst[6:0], [19:15], [24:20], [11:7], [14:12], [31:25].
- `out_fmt` output 6: one-hot {J,U,B,S,I,R} in bits [5:0], with R in bit 0.
- `out_imm` output XLEN: sign-extended immediate.
- `out_illegal` output 1: unsupported encoding.

## Operation
- Decode is combinational on `in_inst` and is captured into the output register on accept (`in_valid & in_ready`).
- Format classes:
  - R: 0110011, 0111011.
  - I: 1100111, 0000011, 0010011, 0011011, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediate construction:
  - I imm: inst[31:20] sign-extended.
  - S imm: {inst[31:25], inst[11:7]} sign-extended.
  - B imm: {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U imm: {inst[31:12], 12'b0} sign-extended to XLEN from bit 31.
  - J imm: {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R-format or illegal: imm = 0.
- `out_illegal` is set when any of the following holds. When set, `out_fmt` = 0 and the raw fields still pass through.
  - inst[1:0] ≠ 2'b11.
  - The opcode is not in the list above.
  - XLEN = 32 and the opcode is 0011011 or 0111011.
- Handshake rules:
  - A beat transfers on the output when `out_valid & out_ready`.
  - `out_valid` is held, with all payload stable, until it transfers.
  - Upstream must hold `in_inst`/`in_pc` while `in_valid & ~in_ready`.
- Flush:
  - `flush` = 1 clears `out_valid` and the skid entry on that edge.
  - A beat presented in the same cycle as `flush` is dropped, even if `in_ready` = 1.
  - Flush has priority over accept and drain.
- Reset:
  - `out_valid` = 0, every payload output = 0, skid empty.
  - `in_ready` = 0 while `rst_n` is low.
  - `in_ready` = 1 in the first cycle after release.
  - Asserting `rst_n` low mid-transfer discards every beat immediately.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on `out_*` after edge N.
- Throughput is 1 beat/cycle when `out_ready` stays high.
- Non-skid build: `in_ready = rst_n & (~out_valid | out_ready)`, which is combinational from `out_ready`.
- Skid build:
  - `in_ready = rst_n & ~skid_valid`, driven from a register with no combinational path from `out_ready`.
  - A beat accepted while `out_valid & ~out_ready` is stored in the skid.
  - When the output transfers and the skid is full, the skid moves to the output on that edge; a new beat cannot be accepted in that cycle, since `in_ready` = 0.
  - Ordering is strictly FIFO.

## Configuration
- `YSYX_23060278_IDU_SKID_EN` defined:
  - A one-entry skid buffer is compiled in.
  - `in_ready` is registered, as described under Timing.
  - The IDU buffers up to 2 beats.
- `YSYX_23060278_IDU_SKID_EN` undefined:
  - Single pipeline register only, holding 1 beat.
  - `in_ready` depends combinationally on `out_ready`.
  - Cycle behaviour with `out_ready` held high is identical to the skid build.

## Test plan
- XLEN=64, inst 0xfff00093 (addi x1,x0,-1), `out_ready`=1 → one cycle later:
  - `out_fmt`=6'b000010, rd=1, rs1=0.
  - imm=0xffff_ffff_ffff_ffff, `out_illegal`=0.
- XLEN=64, U and J immediates:
  - inst 0x800002b7 (lui x5,0x80000) → imm=0xffff_ffff_8000_0000, `out_fmt`=6'b010000.
  - inst 0x008000ef (jal x1,8) → imm=8, `out_fmt`=6'b100000.
- XLEN=32, B-type and RV64-only opcode:
  - inst 0xfe000ee3 (beq x0,x0,-4) → imm=0xffff_fffc, `out_fmt`=6'b001000.
  - inst 0x0010009b (addiw) → `out_illegal`=1, `out_fmt`=0, imm=0.
- Backpressure: stream 4 instructions with `out_ready` low for 3 cycles mid-stream. Required response:
  - All 4 emerge in order with no duplicates or losses.
  - In the skid build, `in_ready` falls only after the second beat is buffered.
- Flush: assert `flush` with `out_valid`=1, the skid full and `in_valid`=1 in the same cycle → next cycle `out_valid`=0 and `in_ready`=1, and the concurrent input beat never appears on the output.
- Reset: drop `rst_n` asynchronously while `out_valid`=1 → `out_valid`=0 and `in_ready`=0 immediately, without waiting for a clock edge. After release, first accept completes on the next edge.
